digit_scan_sequencer: RTL and testbench



---
 rtl/digit_scan_sequencer.sv | 200 ++++++++++++++++++++
 tb/tb_digit_scan_sequencer.sv | 258 +++++++++++++++++++++++++
 2 files changed

// File: rtl/digit_scan_sequencer.sv
// digit_scan_sequencer
// Drives the A/B/En inputs of an active-low 2-to-4 anode decoder for a
// 4-digit display. A prescaler sets the length of each digit slot. The slot
// index steps 0..3, and the nibble for the selected digit is presented to
// the segment encoder. New display words arrive over a valid/ready
// handshake. They are held in a pending register and committed only at the
// 3->0 wrap, so a frame never mixes old and new digits.
//
// Optional build macro: GUARD_BAND_EN
//   When defined, Sel_En is held high (anodes off) for the first GUARD
//   cycles of every slot. This gives anti-ghosting dead time.
//   When undefined, Sel_En follows only the leading-zero blanking rule.
//
// All outputs are registered. Each output register is loaded from the
// next-state values, so Sel_A/Sel_B/Nibble change on the cycle after the
// prescaler tick. They stay aligned with the internal slot index.

module digit_scan_sequencer #(
    parameter int unsigned PRESCALE = 32'd100000,
    parameter int unsigned CW       = 32'd20,
    parameter int unsigned GUARD    = 32'd16
) (
    input  logic        Clk,
    input  logic        Rst_n,
    input  logic [15:0] Value_in,
    input  logic        Load_valid,
    output logic        Load_ready,
    input  logic        Blank_lz,
    output logic        Sel_A,
    output logic        Sel_B,
    output logic        Sel_En,
    output logic [3:0]  Nibble,
    output logic        Frame_done
);

    localparam logic [CW-1:0] TICK_VAL = CW'(PRESCALE - 32'd1);

    // Select the nibble of the display word addressed by the slot index.
    function automatic logic [3:0] nibble_sel(input logic [15:0] word,
                                              input logic [1:0]  idx);
        logic [3:0] nib;
        case (idx)
            2'd0:    nib = word[3:0];
            2'd1:    nib = word[7:4];
            2'd2:    nib = word[11:8];
            2'd3:    nib = word[15:12];
            default: nib = 4'h0;
        endcase
        return nib;
    endfunction

    // A digit is a leading zero when it and every higher digit are zero.
    // Digit 0 is never treated as a leading zero, so a value of 0 still
    // shows a single '0'.
    function automatic logic leading_zero(input logic [15:0] word,
                                          input logic [1:0]  idx);
        logic lz;
        case (idx)
            2'd0:    lz = 1'b0;
            2'd1:    lz = (word[15:4]  == 12'h000);
            2'd2:    lz = (word[15:8]  == 8'h00);
            2'd3:    lz = (word[15:12] == 4'h0);
            default: lz = 1'b0;
        endcase
        return lz;
    endfunction

    // State
    logic [CW-1:0] count_r;
    logic [1:0]    idx_r;
    logic [15:0]   display_r;
    logic [15:0]   pending_r;
    logic          pending_full_r;

    // Next state and events
    logic [CW-1:0] count_next_s;
    logic [1:0]    idx_next_s;
    logic [15:0]   display_next_s;
    logic [15:0]   pending_next_s;
    logic          pending_full_next_s;
    logic          tick_s;
    logic          wrap_s;
    logic          accept_s;
    logic          commit_s;

    // Values computed for the output registers
    logic          sel_a_s;
    logic          sel_b_s;
    logic          sel_en_s;
    logic [3:0]    nibble_s;
    logic          frame_done_s;
    logic          load_ready_s;
    logic          blank_s;
    logic          guard_s;

    // State register: prescaler, slot index, display and pending words.
    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            count_r        <= '0;
            idx_r          <= 2'd0;
            display_r      <= 16'h0000;
            pending_r      <= 16'h0000;
            pending_full_r <= 1'b0;
        end else begin
            count_r        <= count_next_s;
            idx_r          <= idx_next_s;
            display_r      <= display_next_s;
            pending_r      <= pending_next_s;
            pending_full_r <= pending_full_next_s;
        end
    end

    // Next-state logic: prescaler wrap, slot stepping, accept and commit.
    always_comb begin
        tick_s              = (count_r == TICK_VAL);
        wrap_s              = tick_s && (idx_r == 2'd3);
        accept_s            = Load_valid && Load_ready;
        commit_s            = wrap_s && pending_full_r;
        count_next_s        = count_r;
        idx_next_s          = idx_r;
        display_next_s      = display_r;
        pending_next_s      = pending_r;
        pending_full_next_s = pending_full_r;

        if (tick_s) begin
            count_next_s = '0;
            idx_next_s   = idx_r + 2'd1;
        end else begin
            count_next_s = count_r + CW'(1);
            idx_next_s   = idx_r;
        end

        // Accept only happens while ready, and ready implies pending is
        // empty. An accept and a commit therefore never coincide. A word
        // accepted on the wrap tick waits for the following wrap.
        if (accept_s) begin
            pending_next_s      = Value_in;
            pending_full_next_s = 1'b1;
        end else if (commit_s) begin
            display_next_s      = pending_r;
            pending_next_s      = 16'h0000;
            pending_full_next_s = 1'b0;
        end else begin
            pending_next_s      = pending_r;
            pending_full_next_s = pending_full_r;
        end
    end

`ifdef GUARD_BAND_EN
    // Guard band: anodes stay off for the first GUARD cycles of each slot.
    always_comb begin
        guard_s = (count_next_s < CW'(GUARD));
    end
`else
    logic unused_guard_s;

    // Guard band disabled: the blanking rule alone controls the enable.
    always_comb begin
        guard_s        = 1'b0;
        unused_guard_s = ^GUARD;
    end
`endif

    // Output decode from the next state. Ready stays low through the
    // Frame_done cycle of a commit and returns on the cycle after it.
    always_comb begin
        sel_a_s      = idx_next_s[1];
        sel_b_s      = idx_next_s[0];
        nibble_s     = nibble_sel(display_next_s, idx_next_s);
        blank_s      = 1'b0;
        if (Blank_lz) begin
            blank_s = leading_zero(display_next_s, idx_next_s);
        end else begin
            blank_s = 1'b0;
        end
        sel_en_s     = blank_s || guard_s;
        frame_done_s = wrap_s;
        load_ready_s = !(pending_full_next_s || commit_s);
    end

    // Output registers.
    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            Sel_A      <= 1'b0;
            Sel_B      <= 1'b0;
            Sel_En     <= 1'b1;
            Nibble     <= 4'h0;
            Frame_done <= 1'b0;
            Load_ready <= 1'b1;
        end else begin
            Sel_A      <= sel_a_s;
            Sel_B      <= sel_b_s;
            Sel_En     <= sel_en_s;
            Nibble     <= nibble_s;
            Frame_done <= frame_done_s;
            Load_ready <= load_ready_s;
        end
    end

endmodule

// File: tb/tb_digit_scan_sequencer.sv
// Testbench for digit_scan_sequencer.
// The main instance uses PRESCALE=4. A second instance with PRESCALE=8 and
// GUARD=2 exercises the slot enable timing with and without GUARD_BAND_EN.
// Expected per-slot outputs are queued when a word is loaded. They are
// popped and compared when the sequencer shows that frame.

module tb_digit_scan_sequencer;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [15:0] value_in;
    logic        load_valid;
    logic        blank_lz;
    logic        load_ready, sel_a, sel_b, sel_en, frame_done;
    logic [3:0]  nibble;
    logic        ready8, a8, b8, en8, fd8;
    logic [3:0]  nib8;

    int checks   = 0;
    int failures = 0;

    typedef struct {
        logic [15:0] value;
        logic        blank;
        logic [3:0]  en;   // bit s = expected Sel_En in slot s
        logic [15:0] nib;  // nibble s = expected Nibble in slot s
    } vec_t;

    typedef struct {
        logic       a;
        logic       b;
        logic       en;
        logic [3:0] nib;
    } slot_t;

    vec_t  vecs [8];
    slot_t sb_q [$];

    always #5 clk = ~clk;

    digit_scan_sequencer #(.PRESCALE(4), .CW(3), .GUARD(1)) dut (
        .Clk(clk), .Rst_n(rst_n), .Value_in(value_in), .Load_valid(load_valid),
        .Load_ready(load_ready), .Blank_lz(blank_lz), .Sel_A(sel_a), .Sel_B(sel_b),
        .Sel_En(sel_en), .Nibble(nibble), .Frame_done(frame_done)
    );

    digit_scan_sequencer #(.PRESCALE(8), .CW(4), .GUARD(2)) dut8 (
        .Clk(clk), .Rst_n(rst_n), .Value_in(16'h0000), .Load_valid(1'b0),
        .Load_ready(ready8), .Blank_lz(1'b0), .Sel_A(a8), .Sel_B(b8),
        .Sel_En(en8), .Nibble(nib8), .Frame_done(fd8)
    );

    task automatic step();
        @(negedge clk);
    endtask

    task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h expected=%h t=%0t", name, act, exp, $time);
        end
    endtask

    task automatic wait_fd(input string name);
        bit seen;
        seen = 1'b0;
        for (int i = 0; i < 64; i++) begin
            if (!seen) begin
                step();
                if (frame_done === 1'b1) seen = 1'b1;
            end
        end
        checks++;
        if (!seen) begin
            failures++;
            $display("FAIL %s timeout waiting for Frame_done actual=0 expected=1", name);
        end
    endtask

    task automatic wait_ready(input string name);
        bit seen;
        seen = (load_ready === 1'b1);
        for (int i = 0; i < 64; i++) begin
            if (!seen) begin
                step();
                if (load_ready === 1'b1) seen = 1'b1;
            end
        end
        checks++;
        if (!seen) begin
            failures++;
            $display("FAIL %s timeout waiting for Load_ready actual=0 expected=1", name);
        end
    endtask

    task automatic push_frame(input logic [15:0] nib, input logic [3:0] en);
        slot_t e;
        for (int s = 0; s < 4; s++) begin
            e.a   = (s >= 2);
            e.b   = (s % 2 == 1);
            e.en  = en[s];
            e.nib = nib[4*s +: 4];
            sb_q.push_back(e);
        end
    endtask

    // Call on the Frame_done cycle. Samples each slot on its second cycle.
    task automatic verify_frame(input string name);
        slot_t e;
        for (int s = 0; s < 4; s++) begin
            repeat ((s == 0) ? 1 : 4) step();
            if (s == 0) chk({name, ".ready_after_fd"}, {15'd0, load_ready}, 16'd1);
            checks++;
            if (sb_q.size() == 0) begin
                failures++;
                $display("FAIL %s scoreboard empty slot=%0d actual=none expected=entry", name, s);
            end else begin
                e = sb_q.pop_front();
                chk($sformatf("%s.s%0d.a", name, s),   {15'd0, sel_a},  {15'd0, e.a});
                chk($sformatf("%s.s%0d.b", name, s),   {15'd0, sel_b},  {15'd0, e.b});
                chk($sformatf("%s.s%0d.en", name, s),  {15'd0, sel_en}, {15'd0, e.en});
                chk($sformatf("%s.s%0d.nib", name, s), {12'd0, nibble}, {12'd0, e.nib});
            end
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog timeout actual=running expected=finished");
        $fatal(1, "watchdog");
    end

    initial begin
        int  slot;
        bit  exp_en, exp_en8, stale_bad;

        vecs[0] = '{16'h1234, 1'b0, 4'b0000, 16'h1234};
        vecs[1] = '{16'h00A5, 1'b1, 4'b1100, 16'h00A5};
        vecs[2] = '{16'h00A5, 1'b0, 4'b0000, 16'h00A5};
        vecs[3] = '{16'h0000, 1'b1, 4'b1110, 16'h0000};
        vecs[4] = '{16'h0000, 1'b0, 4'b0000, 16'h0000};
        vecs[5] = '{16'h0F00, 1'b1, 4'b1000, 16'h0F00};
        vecs[6] = '{16'h8000, 1'b1, 4'b0000, 16'h8000};
        vecs[7] = '{16'h0001, 1'b1, 4'b1110, 16'h0001};

        rst_n      = 1'b0;
        value_in   = 16'h0000;
        load_valid = 1'b0;
        blank_lz   = 1'b0;
        repeat (3) step();

        // Reset state
        chk("rst.a",     {15'd0, sel_a},      16'd0);
        chk("rst.b",     {15'd0, sel_b},      16'd0);
        chk("rst.en",    {15'd0, sel_en},     16'd1);
        chk("rst.nib",   {12'd0, nibble},     16'd0);
        chk("rst.fd",    {15'd0, frame_done}, 16'd0);
        chk("rst.ready", {15'd0, load_ready}, 16'd1);
        chk("rst.en8",   {15'd0, en8},        16'd1);
        rst_n = 1'b1;

        // Free-running scan with display 0
        for (int n = 1; n <= 33; n++) begin
            step();
            slot = (n / 4) % 4;
`ifdef GUARD_BAND_EN
            exp_en  = (n % 4 < 1);
            exp_en8 = (n % 8 < 2);
`else
            exp_en  = 1'b0;
            exp_en8 = 1'b0;
`endif
            chk($sformatf("scan%0d.a", n),  {15'd0, sel_a},      16'((slot >> 1) & 1));
            chk($sformatf("scan%0d.b", n),  {15'd0, sel_b},      16'(slot & 1));
            chk($sformatf("scan%0d.en", n), {15'd0, sel_en},     {15'd0, exp_en});
            chk($sformatf("scan%0d.fd", n), {15'd0, frame_done}, 16'((n % 16 == 0) ? 1 : 0));
            chk($sformatf("guard%0d.en8", n), {15'd0, en8},      {15'd0, exp_en8});
        end

        // Table-driven loads, one word per frame
        for (int k = 0; k < 8; k++) begin
            wait_ready($sformatf("vec%0d.wait_ready", k));
            value_in   = vecs[k].value;
            blank_lz   = vecs[k].blank;
            load_valid = 1'b1;
            step();
            load_valid = 1'b0;
            value_in   = 16'hDEAD;
            chk($sformatf("vec%0d.ready_drop", k), {15'd0, load_ready}, 16'd0);
            push_frame(vecs[k].nib, vecs[k].en);
            stale_bad = 1'b0;
            for (int i = 0; i < 64; i++) begin
                if (frame_done !== 1'b1) begin
                    step();
                    if (frame_done !== 1'b1 && k == 0 && nibble !== 4'h0) stale_bad = 1'b1;
                end
            end
            chk($sformatf("vec%0d.fd_seen", k), {15'd0, frame_done}, 16'd1);
            if (k == 0) chk("vec0.old_nibble_held", {15'd0, stale_bad}, 16'd0);
            chk($sformatf("vec%0d.ready_at_fd", k), {15'd0, load_ready}, 16'd0);
            verify_frame($sformatf("vec%0d", k));
        end

        // Load on the wrap tick: accepted, shown one frame later
        wait_fd("wrap.sync");
        chk("wrap.ready_idle", {15'd0, load_ready}, 16'd1);
        repeat (15) step();
        value_in   = 16'hBEEF;
        blank_lz   = 1'b0;
        load_valid = 1'b1;
        step();
        chk("wrap.fd",        {15'd0, frame_done}, 16'd1);
        chk("wrap.ready",     {15'd0, load_ready}, 16'd0);
        chk("wrap.old_nib",   {12'd0, nibble},     16'h0001);
`ifdef GUARD_BAND_EN
        chk("wrap.old_en",    {15'd0, sel_en},     16'd1);
`else
        chk("wrap.old_en",    {15'd0, sel_en},     16'd0);
`endif
        value_in = 16'h5555;
        repeat (8) step();
        chk("wrap.second_ignored_ready", {15'd0, load_ready}, 16'd0);
        load_valid = 1'b0;
        push_frame(16'hBEEF, 4'b0000);
        wait_fd("wrap.commit");
        verify_frame("wrap.beef");
        push_frame(16'hBEEF, 4'b0000);
        wait_fd("wrap.next");
        verify_frame("wrap.beef2");

        // Asynchronous reset with a pending word
        value_in   = 16'h9999;
        load_valid = 1'b1;
        step();
        load_valid = 1'b0;
        chk("arst.pending", {15'd0, load_ready}, 16'd0);
        step();
        chk("arst.pre_nib", {12'd0, nibble}, 16'h000B);
        #2 rst_n = 1'b0;
        #1;
        chk("arst.a",     {15'd0, sel_a},      16'd0);
        chk("arst.b",     {15'd0, sel_b},      16'd0);
        chk("arst.en",    {15'd0, sel_en},     16'd1);
        chk("arst.nib",   {12'd0, nibble},     16'd0);
        chk("arst.fd",    {15'd0, frame_done}, 16'd0);
        chk("arst.ready", {15'd0, load_ready}, 16'd1);
        step();
        rst_n = 1'b1;
        push_frame(16'h0000, 4'b0000);
        wait_fd("arst.frame");
        verify_frame("arst.zero");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
